decode_queue: RTL and testbench
===============================

# decode_queue

Parametrised, registered instruction-decode stage. Accepts raw instruction words with their PC over a valid/ready handshake and decodes every base RISC-V format (R/I/S/B/U/J) into register indices, function fields, control flags and a sign-extended immediate. Decoded bundles are held in a DEPTH-entry FIFO, so fetch and execute are decoupled. Sits between fetch and the register-read/execute stage and supports pipeline flush and illegal-instruction flagging.

## Interface
- XLEN, 32: datapath width; 32 or 64; sets imm/pc width and load-funct3 legality.
- DEPTH, 2: FIFO entries; power of two, ≥2.
- CNT_W, 16: width of saturating illegal-instruction counter.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  instruction word present.
- in_ready  out  1  FIFO can accept; = (count != DEPTH); purely from registered count.
- in_inst  in  32  raw instruction.
- in_pc  in  XLEN  instruction address.
- flush  in  1  synchronous flush of all queued entries.
- out_valid  out  1  head entry valid; = (count != 0).
- out_ready  in  1  consumer takes head.
- out_pc  out  XLEN  PC of head.
- out_op  out  7  opcode inst[6:0].
- out_funct3  out  3  inst[14:12], 0 for U/J.
- out_funct7  out  7  inst[31:25] for R-type and shift-immediates, else 0.
- out_rs1, out_rs2, out_rd  out  5 each  register indices, 0 when unused by format.
- out_rs1_used, out_rs2_used, out_rd_we  out  1 each  operand/writeback flags; rd_we=0 when rd==0.
- out_imm  out  XLEN  sign-extended immediate, 0 for R-type.
- out_illegal  out  1  head instruction illegal.
- illegal_cnt  out  CNT_W  count of illegal instructions accepted; saturates at all-ones.

## Operation
- Decode is combinational on in_inst; the decoded bundle is written into the FIFO on push (in_valid && in_ready && !flush).
- Opcodes: R 0110011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BR 1100011, LD 0000011, ST 0100011, IMM 0010011.
- Immediates, sign-extended from bit 31 to XLEN: I = inst[31:20]; S = {inst[31:25],inst[11:7]}; B = {inst[31],inst[7],inst[30:25],inst[11:8],0}; U = {inst[31:12],12'b0}; J = {inst[31],inst[19:12],inst[20],inst[30:21],0}.
- Field use: R rs1,rs2,rd; I (JALR/LD/IMM) rs1,rd; S/B rs1,rs2; U/J rd only. Unused fields forced to 0, flags to 0.
- Illegal when any of: inst[1:0]!=11; opcode not in list; R funct7 not 0000000/0100000 or 0100000 with funct3 not 000/101; JALR funct3!=0; BR funct3 010/011; LD funct3 011/110/111 (XLEN=32; XLEN=64 allows 011 and 110); ST funct3 ≥011 (XLEN=64 allows 011); IMM funct3 001 with funct7!=0, 101 with funct7 not 0/0100000. Illegal entries carry all used-flags/rd_we=0, imm=0, op and pc intact.
- Pop on out_valid && out_ready. Push and pop in same cycle: count unchanged, both pointers advance.
- Full: in_ready=0, input ignored even if out_ready=1 that cycle (no combinational ready path).
- flush: count, pointers cleared next edge; same-cycle push and pop suppressed; illegal_cnt not changed by flush.
- illegal_cnt increments on push of an illegal instruction; holds at 2^CNT_W-1.

## Timing
- Reset (async, rst_n=0): count=0, pointers=0, out_valid=0, in_ready=1, illegal_cnt=0; all out_* data = 0 (FIFO storage reset).
- Latency: instruction pushed at edge N is visible on out_* after edge N (out_valid=1 cycle N+1 when empty).
- Throughput: one instruction per cycle sustained when out_ready held high.
- out_* stable while out_valid && !out_ready (no flush).
- Reset asserted mid-stream discards all entries immediately; no partial state survives.
- Pointer wrap modulo DEPTH; full/empty decided by count (0..DEPTH).

## Test plan
- Reset then push 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid=1, rd=1, rs1=0, rd_we=1, rs1_used=1, imm=5, illegal=0.
- Push 0xFE000EE3 (beq x0,x0,-4) -> imm=0xFFFFFFFC, rs1_used=rs2_used=1, rd=0, rd_we=0; push 0xFFDFF06F (jal x0,-4) -> imm=0xFFFFFFFC, rd_we=0.
- out_ready=0, push 3 instructions, DEPTH=2 -> in_ready=0 after 2nd, 3rd not accepted; then out_ready=1 -> heads emerge in order, no loss/duplication.
- Push 0x00000000 and 0x0000707F -> both out_illegal=1, illegal_cnt=2; with CNT_W=2, 5 illegal pushes -> illegal_cnt=3.
- Fill FIFO, assert flush with in_valid=1 -> next cycle out_valid=0, count=0, in_ready=1, flushed input absent.
- XLEN=64: lui x5,0x80000 (0x800002B7) -> imm=0xFFFFFFFF80000000; ld funct3 011 legal.

Source files
------------

// File: rtl/decode_queue.sv
// decode_queue: RISC-V base-format instruction decoder feeding a DEPTH-entry
// FIFO of decoded bundles. Decode is combinational on the incoming word; the
// FIFO storage, pointers, occupancy and illegal counter are all registers, so
// every output is taken straight from state.
module decode_queue #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [6:0]       out_op,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic             out_rs1_used,
  output logic             out_rs2_used,
  output logic             out_rd_we,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int BW = 2 * XLEN + 36;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;

  localparam logic [PW-1:0]    PTR_ONE   = PW'(1);
  localparam logic [PW:0]      CNT_ONE   = (PW + 1)'(1);
  localparam logic [PW:0]      CNT_DEPTH = (PW + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] ILL_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ILL_MAX   = {CNT_W{1'b1}};

  logic [6:0]       op_s;
  logic [2:0]       f3_s;
  logic [6:0]       f7_s;
  logic             use_rs1_s, use_rs2_s, use_rd_s, keep_f3_s, keep_f7_s;
  logic             bad_s, ill_s;
  logic [31:0]      imm32_s;
  logic [XLEN-1:0]  imm_x_s;
  logic [BW-1:0]    bundle_s;
  logic             push_s, pop_s;

  logic [BW-1:0]    mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r, rd_ptr_r;
  logic [PW:0]      count_r;
  logic [CNT_W-1:0] ill_cnt_r;

  assign op_s    = in_inst[6:0];
  assign f3_s    = in_inst[14:12];
  assign f7_s    = in_inst[31:25];
  // Every legal opcode ends in 2'b11, so the compressed-space check folds in here.
  assign ill_s   = bad_s | (in_inst[1:0] != 2'b11);
  assign imm_x_s = XLEN'($signed(imm32_s));

  // Classify the opcode: field usage, immediate format and legality.
  always_comb begin
    use_rs1_s = 1'b0;
    use_rs2_s = 1'b0;
    use_rd_s  = 1'b0;
    keep_f3_s = 1'b0;
    keep_f7_s = 1'b0;
    bad_s     = 1'b0;
    imm32_s   = 32'd0;
    case (op_s)
      OP_R: begin
        use_rs1_s = 1'b1; use_rs2_s = 1'b1; use_rd_s = 1'b1;
        keep_f3_s = 1'b1; keep_f7_s = 1'b1;
        if (f7_s == 7'b0000000) begin
          bad_s = 1'b0;
        end else if (f7_s == 7'b0100000) begin
          bad_s = !((f3_s == 3'b000) || (f3_s == 3'b101));
        end else begin
          bad_s = 1'b1;
        end
      end
      OP_LUI, OP_AUIPC: begin
        use_rd_s = 1'b1;
        imm32_s  = {in_inst[31:12], 12'b0};
      end
      OP_JAL: begin
        use_rd_s = 1'b1;
        imm32_s  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                    in_inst[30:21], 1'b0};
      end
      OP_JALR: begin
        use_rs1_s = 1'b1; use_rd_s = 1'b1; keep_f3_s = 1'b1;
        imm32_s   = {{20{in_inst[31]}}, in_inst[31:20]};
        bad_s     = (f3_s != 3'b000);
      end
      OP_BR: begin
        use_rs1_s = 1'b1; use_rs2_s = 1'b1; keep_f3_s = 1'b1;
        imm32_s   = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                     in_inst[11:8], 1'b0};
        bad_s     = (f3_s == 3'b010) || (f3_s == 3'b011);
      end
      OP_LD: begin
        use_rs1_s = 1'b1; use_rd_s = 1'b1; keep_f3_s = 1'b1;
        imm32_s   = {{20{in_inst[31]}}, in_inst[31:20]};
        case (f3_s)
          3'b000, 3'b001, 3'b010, 3'b100, 3'b101: bad_s = 1'b0;
          3'b011, 3'b110:                         bad_s = (XLEN != 64);
          default:                                bad_s = 1'b1;
        endcase
      end
      OP_ST: begin
        use_rs1_s = 1'b1; use_rs2_s = 1'b1; keep_f3_s = 1'b1;
        imm32_s   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        case (f3_s)
          3'b000, 3'b001, 3'b010: bad_s = 1'b0;
          3'b011:                 bad_s = (XLEN != 64);
          default:                bad_s = 1'b1;
        endcase
      end
      OP_IMM: begin
        use_rs1_s = 1'b1; use_rd_s = 1'b1; keep_f3_s = 1'b1;
        imm32_s   = {{20{in_inst[31]}}, in_inst[31:20]};
        if (f3_s == 3'b001) begin
          keep_f7_s = 1'b1;
          bad_s     = (f7_s != 7'b0000000);
        end else if (f3_s == 3'b101) begin
          keep_f7_s = 1'b1;
          bad_s     = !((f7_s == 7'b0000000) || (f7_s == 7'b0100000));
        end else begin
          bad_s     = 1'b0;
        end
      end
      default: bad_s = 1'b1;
    endcase
  end

  // Assemble the bundle; an illegal word keeps only its pc and opcode.
  always_comb begin
    bundle_s = {BW{1'b0}};
    if (ill_s) begin
      bundle_s = {in_pc, op_s, 3'b000, 7'b0000000, 15'd0, 3'b000, {XLEN{1'b0}}, 1'b1};
    end else begin
      bundle_s = {in_pc, op_s,
                  keep_f3_s ? f3_s : 3'b000,
                  keep_f7_s ? f7_s : 7'b0000000,
                  use_rs1_s ? in_inst[19:15] : 5'd0,
                  use_rs2_s ? in_inst[24:20] : 5'd0,
                  use_rd_s  ? in_inst[11:7]  : 5'd0,
                  use_rs1_s, use_rs2_s,
                  use_rd_s && (in_inst[11:7] != 5'd0),
                  imm_x_s, 1'b0};
    end
  end

  assign in_ready  = (count_r != CNT_DEPTH);
  assign out_valid = (count_r != {(PW + 1){1'b0}});
  assign push_s    = in_valid && in_ready && !flush;
  assign pop_s     = out_valid && out_ready && !flush;

  assign {out_pc, out_op, out_funct3, out_funct7, out_rs1, out_rs2, out_rd,
          out_rs1_used, out_rs2_used, out_rd_we, out_imm, out_illegal} = mem_r[rd_ptr_r];
  assign illegal_cnt = ill_cnt_r;

  // FIFO storage, pointers and occupancy; flush empties the queue without touching data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {BW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW + 1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW + 1){1'b0}};
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= bundle_s;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + CNT_ONE;
      end else if (pop_s && !push_s) begin
        count_r <= count_r - CNT_ONE;
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Saturating count of illegal words accepted into the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ill_cnt_r <= {CNT_W{1'b0}};
    end else if (push_s && ill_s && (ill_cnt_r != ILL_MAX)) begin
      ill_cnt_r <= ill_cnt_r + ILL_ONE;
    end else begin
      ill_cnt_r <= ill_cnt_r;
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: stimulus pushes hand-decoded expected
// bundles into a queue, a monitor pops and compares on every DUT handshake.
module tb_decode_queue;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rs1, rs2, rd;
    logic        u1, u2, we;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] in_inst = 32'd0, in_pc = 32'd0;
  logic        in_ready, out_valid, out_rs1_used, out_rs2_used, out_rd_we, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [6:0]  out_op, out_funct7;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [1:0]  illegal_cnt;

  decode_queue #(.XLEN(32), .DEPTH(2), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op), .out_funct3(out_funct3),
    .out_funct7(out_funct7), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_rs1_used(out_rs1_used), .out_rs2_used(out_rs2_used), .out_rd_we(out_rd_we),
    .out_imm(out_imm), .out_illegal(out_illegal), .illegal_cnt(illegal_cnt));

  logic        v64 = 1'b0, r64 = 1'b1;
  logic [31:0] inst64 = 32'd0;
  logic [63:0] pc64 = 64'd0;
  logic        rdy64, ov64, u1_64, u2_64, we64, ill64;
  logic [63:0] opc64, imm64;
  logic [6:0]  op64, f7_64;
  logic [2:0]  f3_64;
  logic [4:0]  rs1_64, rs2_64, rd64;
  logic [15:0] cnt64;

  decode_queue #(.XLEN(64), .DEPTH(2), .CNT_W(16)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(rdy64),
    .in_inst(inst64), .in_pc(pc64), .flush(1'b0), .out_valid(ov64),
    .out_ready(r64), .out_pc(opc64), .out_op(op64), .out_funct3(f3_64),
    .out_funct7(f7_64), .out_rs1(rs1_64), .out_rs2(rs2_64), .out_rd(rd64),
    .out_rs1_used(u1_64), .out_rs2_used(u2_64), .out_rd_we(we64),
    .out_imm(imm64), .out_illegal(ill64), .illegal_cnt(cnt64));

  int   n_pass = 0;
  int   n_total = 0;
  exp_t expq[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic exp_t ex(input logic [31:0] pc, input logic [6:0] op,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic u1, input logic u2,
                              input logic we, input logic [31:0] imm);
    exp_t e;
    e = '{pc: pc, op: op, f3: f3, f7: f7, rs1: rs1, rs2: rs2, rd: rd,
          u1: u1, u2: u2, we: we, imm: imm, ill: 1'b0};
    return e;
  endfunction

  function automatic exp_t ix(input logic [31:0] pc, input logic [6:0] op);
    exp_t e;
    e = ex(pc, op, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0);
    e.ill = 1'b1;
    return e;
  endfunction

  // Push one word, recording its expected bundle once the DUT accepts it.
  task automatic push(input logic [31:0] inst, input logic [31:0] pc, input exp_t e);
    bit acc = 1'b0;
    in_valid = 1'b1; in_inst = inst; in_pc = pc;
    for (int n = 0; n < 50 && !acc; n++) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        expq.push_back(e);
        acc = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("push_timeout", 128'd0, 128'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: compare the head against the scoreboard on every pop.
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        a = '{pc: out_pc, op: out_op, f3: out_funct3, f7: out_funct7, rs1: out_rs1,
              rs2: out_rs2, rd: out_rd, u1: out_rs1_used, u2: out_rs2_used,
              we: out_rd_we, imm: out_imm, ill: out_illegal};
        if (expq.size() == 0) begin
          chk("unexpected_output", a, 128'd0);
        end else begin
          e = expq.pop_front();
          chk($sformatf("pop_pc_%0h", e.pc), a, e);
        end
      end
    end
  end

  initial begin
    idle(2);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_illegal_cnt", illegal_cnt, 2'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_imm", out_imm, 32'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(1);

    // addi x1,x0,5 then beq x0,x0,-4 and jal x0,-4 back to back.
    push(32'h00500093, 32'h100, ex(32'h100, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1, 32'd5));
    chk("latency_out_valid", out_valid, 1'b1);
    push(32'hFE000EE3, 32'h104, ex(32'h104, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFC));
    push(32'hFFDFF06F, 32'h108, ex(32'h108, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFC));
    idle(3);

    // Fill with consumer stalled; a third word offered while full must be dropped.
    out_ready = 1'b0;
    push(32'h002081B3, 32'h200, ex(32'h200, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 32'd0));
    push(32'h40208233, 32'h204, ex(32'h204, 7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 32'd0));
    chk("full_in_ready", in_ready, 1'b0);
    in_valid = 1'b1; in_inst = 32'h0020A423; in_pc = 32'h208;
    idle(1);
    in_valid = 1'b0;
    chk("stall_head_pc", out_pc, 32'h200);
    out_ready = 1'b1;
    idle(3);
    chk("drained_out_valid", out_valid, 1'b0);
    push(32'h0020A423, 32'h20C, ex(32'h20C, 7'h23, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0, 32'd8));
    idle(2);

    // Illegal words: quadrant, unknown opcode, then three more to saturate a 2-bit counter.
    push(32'h00000000, 32'h300, ix(32'h300, 7'h00));
    push(32'h0000707F, 32'h304, ix(32'h304, 7'h7F));
    idle(2);
    chk("illegal_cnt_2", illegal_cnt, 2'd2);
    push(32'h00003003, 32'h308, ix(32'h308, 7'h03));
    push(32'h00001067, 32'h30C, ix(32'h30C, 7'h67));
    push(32'h02000033, 32'h310, ix(32'h310, 7'h33));
    idle(2);
    chk("illegal_cnt_sat", illegal_cnt, 2'd3);

    // Flush a full queue while offering a word; neither old nor offered word may emerge.
    out_ready = 1'b0;
    push(32'h002081B3, 32'h400, ex(32'h400, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 32'd0));
    push(32'h40208233, 32'h404, ex(32'h404, 7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd4, 1'b1, 1'b1, 1'b1, 32'd0));
    expq.delete();
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'hFFDFF06F; in_pc = 32'h408;
    idle(1);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    chk("flush_illegal_cnt", illegal_cnt, 2'd3);
    out_ready = 1'b1;
    push(32'h00500093, 32'h500, ex(32'h500, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1, 32'd5));
    idle(2);

    // Reset mid-stream discards the held entry immediately.
    out_ready = 1'b0;
    push(32'h002081B3, 32'h600, ex(32'h600, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 32'd0));
    rst_n = 1'b0;
    #1;
    expq.delete();
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_illegal_cnt", illegal_cnt, 2'd0);
    idle(1);
    rst_n = 1'b1;
    idle(1);

    // XLEN=64: lui sign-extends to 64 bits; ld (funct3 011) is legal.
    v64 = 1'b1; inst64 = 32'h800002B7; pc64 = 64'h1000;
    idle(1);
    chk("x64_lui_valid", ov64, 1'b1);
    chk("x64_lui_imm", imm64, 64'hFFFFFFFF80000000);
    chk("x64_lui_rd", {rd64, we64, ill64}, {5'd5, 1'b1, 1'b0});
    inst64 = 32'h0002B303; pc64 = 64'h1004;
    idle(1);
    v64 = 1'b0;
    chk("x64_ld_legal", ill64, 1'b0);
    chk("x64_ld_fields", {opc64, f3_64, rs1_64, rd64, u1_64, we64}, {64'h1004, 3'd3, 5'd5, 5'd6, 1'b1, 1'b1});
    chk("x64_ld_imm", imm64, 64'd0);
    idle(2);

    chk("scoreboard_empty", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
